uart_rx_frame_fifo: RTL and testbench

Downstream consumer of the UART receiver. Accepts each completed raw frame on a one-cycle done pulse and extracts the data bits. Checks parity and the stop bit and flags line breaks. Buffers results in a first-word-fall-through FIFO with a valid/ready output towards the host logic, plus overflow status and a drop counter.

---
 rtl/uart_rx_frame_fifo.sv | 117 +++++++++++
 tb/tb_uart_rx_frame_fifo.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_fifo.sv
// uart_rx_frame_fifo: decodes raw UART frames (data, parity, stop, break)
// and buffers the results in a first-word-fall-through FIFO with a
// valid/ready interface, sticky overflow flag and saturating drop counter.
module uart_rx_frame_fifo #(
    parameter int FRAME_BITS = 10,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [FRAME_BITS-1:0]           in_frame,
    input  logic                            in_valid,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_BITS-1:0]            out_data,
    output logic                            out_parity_err,
    output logic                            out_frame_err,
    output logic                            out_break,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow,
    output logic [7:0]                      drop_count,
    input  logic                            clear_status
);

    localparam int   AW      = $clog2(FIFO_DEPTH);
    localparam int   CW      = AW + 1;
    localparam int   EW      = DATA_BITS + 3;
    localparam logic ODD_BIT = (PARITY_ODD != 0);
    localparam logic PAR_ON  = (PARITY_EN != 0);

    // Drop counter saturates at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [DATA_BITS-1:0] dec_data;
    logic                 dec_stop;
    logic                 dec_par_bit;
    logic                 dec_parity_err;
    logic                 dec_frame_err;
    logic                 dec_break;
    logic                 unused_frame_bits;

    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]        rd_ptr;
    logic [AW-1:0]        wr_ptr;
    logic [CW-1:0]        count;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 drop;
    logic [EW-1:0]        head;

    // Frame decode; bits above the stop bit are don't-care.
    always_comb begin
        dec_data          = in_frame[DATA_BITS-1:0];
        dec_stop          = in_frame[DATA_BITS+PARITY_EN];
        dec_par_bit       = in_frame[DATA_BITS];
        dec_parity_err    = PAR_ON & ((^dec_data) ^ dec_par_bit ^ ODD_BIT);
        dec_frame_err     = ~dec_stop;
        dec_break         = dec_frame_err & (dec_data == '0);
        unused_frame_bits = ^in_frame;
    end

    // Handshake decisions; a full FIFO still accepts when the head leaves this cycle.
    always_comb begin
        full  = (count == CW'(FIFO_DEPTH));
        pop   = out_valid & out_ready;
        push  = in_valid & (~full | pop) & ~reset;
        drop  = in_valid & full & ~pop;
        head  = out_valid ? mem[rd_ptr] : '0;
    end

    assign out_valid      = (count != '0);
    assign fifo_count     = count;
    assign out_data       = head[DATA_BITS-1:0];
    assign out_parity_err = head[DATA_BITS];
    assign out_frame_err  = head[DATA_BITS+1];
    assign out_break      = head[DATA_BITS+2];

    // Storage array is written on push only; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {dec_break, dec_frame_err, dec_parity_err, dec_data};
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Overflow status; a drop in the same cycle as a clear takes precedence.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else if (drop) begin
            overflow   <= 1'b1;
            drop_count <= clear_status ? 8'd1 : sat_inc(drop_count);
        end else if (clear_status) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_fifo.sv
// Directed testbench for uart_rx_frame_fifo with a queue-based scoreboard.
module tb_uart_rx_frame_fifo;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       brk;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] in_frame;
    logic       in_valid;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_parity_err;
    logic       out_frame_err;
    logic       out_break;
    logic [4:0] fifo_count;
    logic       overflow;
    logic [7:0] drop_count;
    logic       clear_status;

    logic       odd_valid;
    logic       odd_out_valid;
    logic [7:0] odd_out_data;
    logic       odd_parity_err;
    logic       odd_frame_err;
    logic       odd_break;
    logic [4:0] odd_count;
    logic       odd_overflow;
    logic [7:0] odd_drop_count;

    ent_t sb[$];
    bit   m_ovf;
    int   m_drop;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    uart_rx_frame_fifo dut (
        .clk(clk), .reset(reset), .in_frame(in_frame), .in_valid(in_valid),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_parity_err(out_parity_err), .out_frame_err(out_frame_err),
        .out_break(out_break), .fifo_count(fifo_count), .overflow(overflow),
        .drop_count(drop_count), .clear_status(clear_status)
    );

    uart_rx_frame_fifo #(.PARITY_ODD(1)) u_odd (
        .clk(clk), .reset(reset), .in_frame(in_frame), .in_valid(odd_valid),
        .out_valid(odd_out_valid), .out_ready(1'b1), .out_data(odd_out_data),
        .out_parity_err(odd_parity_err), .out_frame_err(odd_frame_err),
        .out_break(odd_break), .fifo_count(odd_count), .overflow(odd_overflow),
        .drop_count(odd_drop_count), .clear_status(1'b0)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic ent_t decode(input logic [9:0] f, input bit odd);
        ent_t e;
        int   ones;
        ones = 0;
        for (int i = 0; i < 9; i++) ones += int'(f[i]);
        e.d   = f[7:0];
        e.pe  = ((ones % 2) == 1) != odd;
        e.fe  = (f[9] == 1'b0);
        e.brk = e.fe && (f[7:0] == 8'h00);
        return e;
    endfunction

    function automatic logic [9:0] good_frame(input logic [7:0] d);
        return {1'b1, ^d, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag);
        chk({tag, "_data"}, 32'(out_data), 32'(sb[0].d));
        chk({tag, "_perr"}, 32'(out_parity_err), 32'(sb[0].pe));
        chk({tag, "_ferr"}, 32'(out_frame_err), 32'(sb[0].fe));
        chk({tag, "_brk"}, 32'(out_break), 32'(sb[0].brk));
    endtask

    task automatic check_state();
        chk("count", 32'(fifo_count), 32'(sb.size()));
        chk("valid", 32'(out_valid), 32'(sb.size() != 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_count", 32'(drop_count), 32'(m_drop));
        if (sb.size() != 0) begin
            check_head("head");
        end else begin
            chk("empty_outs", {28'd0, out_data[7:4] | out_data[3:0]},
                32'd0);
            chk("empty_flags", 32'({out_parity_err, out_frame_err, out_break}), 32'd0);
        end
    endtask

    // One clock: apply inputs, update scoreboard, advance, then check outputs.
    task automatic step(input logic v, input logic [9:0] f, input logic rdy,
                        input logic clr, input logic rst);
        bit   pop;
        bit   full;
        ent_t tmp;
        in_valid = v; in_frame = f; out_ready = rdy; clear_status = clr; reset = rst;
        #1;
        if (rst) begin
            sb.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            full = (sb.size() == 16);
            pop  = rdy && (sb.size() != 0);
            if (pop) begin
                check_head("pop");
                tmp = sb.pop_front();
            end
            if (v && (!full || pop)) sb.push_back(decode(f, 1'b0));
            if (v && full && !pop) begin
                m_ovf  = 1'b1;
                m_drop = clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
            end else if (clr) begin
                m_ovf  = 1'b0;
                m_drop = 0;
            end
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    initial begin
        reset = 1'b1; in_frame = '0; in_valid = 1'b0; out_ready = 1'b0;
        clear_status = 1'b0; odd_valid = 1'b0;
        m_ovf = 1'b0; m_drop = 0;

        step(1'b0, 10'd0, 1'b0, 1'b0, 1'b1);
        chk("reset_count", 32'(fifo_count), 32'd0);
        chk("reset_valid", 32'(out_valid), 32'd0);

        // First good frame, then drain.
        step(1'b1, 10'b1_0_01010101, 1'b0, 1'b0, 1'b0);
        chk("first_data", 32'(out_data), 32'h55);
        chk("first_count", 32'(fifo_count), 32'd1);
        step(1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
        chk("first_empty", 32'(out_valid), 32'd0);

        // Parity error, then break frame.
        step(1'b1, 10'b1_1_01010101, 1'b0, 1'b0, 1'b0);
        chk("perr_flag", 32'(out_parity_err), 32'd1);
        step(1'b1, 10'b0_0_00000000, 1'b1, 1'b0, 1'b0);
        chk("break_ferr", 32'(out_frame_err), 32'd1);
        chk("break_flag", 32'(out_break), 32'd1);
        step(1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 10'd0, 1'b1, 1'b0, 1'b0);

        // Odd-parity instance: 0x55 with parity 1 is correct.
        in_frame = 10'b1_1_01010101; odd_valid = 1'b1;
        @(posedge clk); #1;
        odd_valid = 1'b0;
        chk("odd_valid", 32'(odd_out_valid), 32'd1);
        chk("odd_data", 32'(odd_out_data), 32'h55);
        chk("odd_perr", 32'(odd_parity_err), 32'd0);

        // Empty FIFO with ready high does nothing.
        step(1'b0, 10'd0, 1'b1, 1'b0, 1'b0);

        // Fill to 16, then overflow by one.
        for (int i = 0; i < 16; i++) step(1'b1, good_frame(8'(i)), 1'b0, 1'b0, 1'b0);
        chk("full_count", 32'(fifo_count), 32'd16);
        step(1'b1, good_frame(8'd99), 1'b0, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_drops", 32'(drop_count), 32'd1);

        // Drain in order, then pointer wrap with 4 more.
        for (int i = 0; i < 16; i++) step(1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, good_frame(8'(8'hA0 + i)), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 10'd0, 1'b1, 1'b0, 1'b0);

        // Refill, clear status, push and pop together while full.
        for (int i = 0; i < 16; i++) step(1'b1, good_frame(8'(8'h30 + i)), 1'b0, 1'b0, 1'b0);
        step(1'b0, 10'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 10'b0_1_11110000, 1'b1, 1'b0, 1'b0);
        chk("pp_count", 32'(fifo_count), 32'd16);
        chk("pp_ovf", 32'(overflow), 32'd0);

        // Saturating drop counter.
        for (int i = 0; i < 300; i++) step(1'b1, good_frame(8'(i)), 1'b0, 1'b0, 1'b0);
        chk("sat_drops", 32'(drop_count), 32'd255);
        step(1'b1, good_frame(8'h11), 1'b0, 1'b1, 1'b0);
        chk("clr_drop_ovf", 32'(overflow), 32'd1);
        chk("clr_drop_cnt", 32'(drop_count), 32'd1);
        step(1'b0, 10'd0, 1'b0, 1'b1, 1'b0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_cnt", 32'(drop_count), 32'd0);

        // Reset mid-stream with 5 entries stored and in_valid high.
        step(1'b1, good_frame(8'h22), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(fifo_count), 32'd5);
        step(1'b1, good_frame(8'h77), 1'b0, 1'b0, 1'b1);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        step(1'b0, 10'd0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
